// File: rtl/alu_sequencer.sv
// Sequences one command at a time through an external ALU: issue, wait WAIT_CYCLES, capture, respond.
// Latency: rsp_valid 2+WAIT_CYCLES cycles after accept (1 cycle for rejected ops); rsp held until rsp_ready, no overlap.
module alu_sequencer #(
    parameter int WIDTH       = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_chain,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [6:0]       alu_out_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] OP_MULT   = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             chain_q, chain_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_error_q, rsp_error_d;
    logic             has_result_q, has_result_d;
    logic             cmd_fire;
    logic             reject;
    logic             capture_err;
    logic [6:0]       op_onehot;

    always_comb begin
        op_onehot = 7'b0000000;
        if (op_q != OP_RSVD) begin
            op_onehot = 7'b1000000 >> op_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        chain_d      = chain_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_error_d  = rsp_error_q;
        has_result_d = has_result_q;
        cmd_ready    = (state_q == IDLE) & on & ~rst;
        cmd_fire     = cmd_valid & cmd_ready;
        // Chaining needs a persisted ALU value that came from an error-free result.
        reject       = (cmd_op == OP_RSVD) | (cmd_chain & ~has_result_q);
        capture_err  = alu_overflow & (op_q == OP_MULT);

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    op_d    = cmd_op;
                    chain_d = cmd_chain;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    if (reject) begin
                        state_d      = RESP;
                        rsp_data_d   = '0;
                        rsp_error_d  = 1'b1;
                        has_result_d = 1'b0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = WAIT_LAST;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    rsp_data_d   = alu_result;
                    rsp_error_d  = capture_err;
                    has_result_d = ~capture_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_in_sel  = 3'b000;
        alu_num1    = '0;
        alu_num2    = '0;
        alu_out_sel = 7'b0000000;
        if (state_q == ISSUE || state_q == WAIT) begin
            alu_num1    = a_q;
            alu_num2    = b_q;
            alu_out_sel = op_onehot;
        end
        if (state_q == ISSUE) begin
            alu_in_sel = chain_q ? 3'b100 : 3'b010;
        end
        if (rst) begin
            alu_in_sel = 3'b001;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 3'd0;
            chain_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= 4'd0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
            has_result_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            chain_q      <= chain_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
            has_result_q <= has_result_d;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: external ALU device, expected-response queue, independent monitor.
module tb_alu_sequencer;
    localparam int WIDTH       = 8;
    localparam int WAIT_CYCLES = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             on = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic             cmd_chain = 1'b0;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic [2:0]       alu_in_sel;
    logic [WIDTH-1:0] alu_num1;
    logic [WIDTH-1:0] alu_num2;
    logic [6:0]       alu_out_sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_error;
    logic             busy;

    alu_sequencer #(.WIDTH(WIDTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .rst(rst), .on(on),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_out_sel(alu_out_sel),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit hold_rdy = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    // Reference state: does a chainable result exist, and what was it.
    bit         m_has = 1'b0;
    logic [7:0] m_last = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_push(input logic [2:0] op, input logic ch, input logic [7:0] a,
                              input logic [7:0] b, input int n);
        exp_t e;
        int   opa;
        int   res;
        e.err = 1'b0;
        if (op == 3'd7 || (ch && !m_has)) begin
            e.data = 8'h00;
            e.err  = 1'b1;
            e.due  = n + 1;
            m_has  = 1'b0;
        end else begin
            opa = ch ? int'(m_last) : int'(a);
            case (op)
                3'd0:    res = opa & int'(b);
                3'd1:    res = opa | int'(b);
                3'd2:    res = ~opa;
                3'd3:    res = opa ^ int'(b);
                3'd4:    res = opa + int'(b);
                3'd5:    res = opa - int'(b);
                default: begin
                    res   = opa * int'(b);
                    e.err = (res > 255);
                end
            endcase
            e.data = res[7:0];
            e.due  = n + 2 + WAIT_CYCLES;
            m_has  = !e.err;
            if (!e.err) m_last = e.data;
        end
        exp_q.push_back(e);
    endtask

    // External ALU device: computes on a load/persist strobe, result visible from the next cycle.
    logic [7:0] alu_acc;
    always @(posedge clk) begin : alu_model
        logic [7:0]  opa;
        logic [7:0]  r;
        logic [15:0] prod;
        logic        c;
        r = 8'h00; c = 1'b0; prod = 16'h0000;
        opa = (alu_in_sel == 3'b100) ? alu_acc : alu_num1;
        if (alu_in_sel == 3'b001) begin
            alu_acc <= 8'h00; alu_result <= 8'h00; alu_overflow <= 1'b0;
        end else if (alu_in_sel == 3'b010 || alu_in_sel == 3'b100) begin
            case (alu_out_sel)
                7'b1000000: r = opa & alu_num2;
                7'b0100000: r = opa | alu_num2;
                7'b0010000: r = ~opa;
                7'b0001000: r = opa ^ alu_num2;
                7'b0000100: {c, r} = {1'b0, opa} + {1'b0, alu_num2};
                7'b0000010: {c, r} = {1'b0, opa} - {1'b0, alu_num2};
                7'b0000001: begin
                    prod = opa * alu_num2;
                    r    = prod[7:0];
                    c    = (prod[15:8] != 8'h00);
                end
                default: r = 8'hEE;
            endcase
            alu_acc <= r; alu_result <= r; alu_overflow <= c;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: samples mid-cycle, pops the scoreboard on every response handshake.
    initial begin : monitor
        exp_t cur;
        bit   in_rsp;
        in_rsp = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (rst) begin
                in_rsp = 1'b0;
            end else begin
                if (!busy) begin
                    chk("idle_in_sel", alu_in_sel, 3'b000);
                    chk("idle_out_sel", alu_out_sel, 7'b0000000);
                    chk("idle_num1", alu_num1, 8'h00);
                    chk("idle_num2", alu_num2, 8'h00);
                end
                if (rsp_valid) begin
                    chk("rsp_cmd_ready", cmd_ready, 1'b0);
                    if (!in_rsp) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_rsp actual=rsp_valid_high expected=no_response (cycle %0d)", cyc);
                        end else begin
                            cur    = exp_q[0];
                            in_rsp = 1'b1;
                            chk("rsp_latency", cyc, cur.due);
                        end
                    end
                    if (in_rsp) begin
                        chk("rsp_data", rsp_data, cur.data);
                        chk("rsp_error", rsp_error, cur.err);
                        chk("rsp_in_sel", alu_in_sel, 3'b000);
                        if (rsp_ready) begin
                            void'(exp_q.pop_front());
                            in_rsp = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Returns at negedge+1 of the cycle after the handshake (ISSUE, or RESP for rejected ops).
    task automatic send(input logic [2:0] op, input logic ch, input logic [7:0] a,
                        input logic [7:0] b, input bit rnd_on, output int n);
        int tries;
        bit done;
        tries = 0;
        done  = 1'b0;
        n     = -1;
        @(negedge clk);
        cmd_op = op; cmd_chain = ch; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!done) begin
            if (rnd_on) on = ($urandom_range(0, 3) != 0);
            #1;
            if (cmd_ready === 1'b1) begin
                n = cyc;
                model_push(op, ch, a, b, n);
                done = 1'b1;
            end else if (tries >= 300) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=cmd_ready_low expected=accept (cycle %0d)", cyc);
                done = 1'b1;
            end else begin
                tries++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("wait_idle_done", (t < 500), 1'b1);
    endtask

    initial begin : stimulus
        int n;
        rst = 1'b1;
        on  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_sel", alu_in_sel, 3'b001);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_error", rsp_error, 1'b0);
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        send(3'd4, 1'b0, 8'h12, 8'h34, 1'b0, n);
        chk("add_issue_cyc", cyc, n + 1);
        chk("add_issue_in_sel", alu_in_sel, 3'b010);
        chk("add_issue_out_sel", alu_out_sel, 7'b0000100);
        chk("add_issue_num1", alu_num1, 8'h12);
        chk("add_issue_num2", alu_num2, 8'h34);
        @(negedge clk);
        #1;
        chk("add_wait_in_sel", alu_in_sel, 3'b000);
        chk("add_wait_out_sel", alu_out_sel, 7'b0000100);
        chk("add_wait_num1", alu_num1, 8'h12);
        wait_idle();

        send(3'd5, 1'b1, 8'h00, 8'h06, 1'b0, n);
        chk("chain_issue_in_sel", alu_in_sel, 3'b100);
        chk("chain_issue_out_sel", alu_out_sel, 7'b0000010);
        wait_idle();

        send(3'd6, 1'b0, 8'h20, 8'h10, 1'b0, n);
        chk("mult_issue_out_sel", alu_out_sel, 7'b0000001);
        wait_idle();
        send(3'd5, 1'b1, 8'h00, 8'h01, 1'b0, n);
        chk("chain_err_rsp_valid", rsp_valid, 1'b1);
        chk("chain_err_in_sel", alu_in_sel, 3'b000);
        chk("chain_err_error", rsp_error, 1'b1);
        wait_idle();

        hold_rdy = 1'b1;
        send(3'd7, 1'b0, 8'hAA, 8'h55, 1'b0, n);
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rsvd_hold_valid", rsp_valid, 1'b1);
            chk("rsvd_hold_data", rsp_data, 8'h00);
            chk("rsvd_hold_error", rsp_error, 1'b1);
            chk("rsvd_hold_cmd_ready", cmd_ready, 1'b0);
            chk("rsvd_hold_in_sel", alu_in_sel, 3'b000);
            @(negedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        hold_rdy  = 1'b0;
        wait_idle();

        send(3'd4, 1'b0, 8'h01, 8'h02, 1'b0, n);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        m_has = 1'b0;
        #1;
        chk("midwait_rst_in_sel", alu_in_sel, 3'b001);
        chk("midwait_rst_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midwait_rst_busy", busy, 1'b0);
        chk("midwait_rst_rsp_valid", rsp_valid, 1'b0);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("midwait_rst_no_rsp", rsp_valid, 1'b0);
        end

        on = 1'b0;
        cmd_op = 3'd4; cmd_chain = 1'b0; cmd_a = 8'h05; cmd_b = 8'h06;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("off_cmd_ready", cmd_ready, 1'b0);
            chk("off_busy", busy, 1'b0);
        end
        cmd_valid = 1'b0;
        on = 1'b1;
        send(3'd4, 1'b0, 8'h10, 8'h20, 1'b0, n);
        on = 1'b0;
        wait_idle();
        on = 1'b1;

        for (int k = 0; k < 80; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, n);
        end
        on = 1'b1;
        wait_idle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
